// File: rtl/rob_complete_arbiter.sv
// rob_complete_arbiter: round-robin merge of unit completions onto the ROB port.
// Ports: clk/rst/flush; per-unit req_* in, req_ready out; registered ex_* out; completions.
module rob_complete_arbiter #(
  parameter  int NUM_UNITS  = 4,
  parameter  int RS_ENTRIES = 16,
  parameter  int DATA_W     = 32,
  parameter  int CNT_W      = 32,
  localparam int IDX_W      = $clog2(RS_ENTRIES),
  localparam int PTR_W      = $clog2(NUM_UNITS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_UNITS-1:0]        req_valid,
  output logic [NUM_UNITS-1:0]        req_ready,
  input  logic [NUM_UNITS*IDX_W-1:0]  req_entry_index,
  input  logic [NUM_UNITS*DATA_W-1:0] req_ex_val,
  input  logic [NUM_UNITS-1:0]        req_br_mispred,
  input  logic [NUM_UNITS-1:0]        req_exception,
  output logic                        ex_valid,
  output logic [IDX_W-1:0]            entry_index,
  output logic [DATA_W-1:0]           ex_val,
  output logic                        br_mispred,
  output logic                        exception,
  output logic [CNT_W-1:0]            completions
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_UNITS-1);

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     probe;
  logic [PTR_W-1:0]     nxt_ptr;
  logic                 found;
  logic                 xfer;
  logic [NUM_UNITS-1:0] gnt_oh;
  logic [IDX_W-1:0]     sel_idx;
  logic [DATA_W-1:0]    sel_val;
  logic                 sel_bm;
  logic                 sel_ex;

  // Walk the units starting at rr_ptr; first valid one wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    probe   = rr_ptr;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!found && req_valid[probe]) begin
        found   = 1'b1;
        gnt_idx = probe;
      end
      probe = (probe == LAST) ? '0 : probe + PTR_W'(1);
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (found && !flush && !rst)
      gnt_oh[gnt_idx] = 1'b1;
  end

  assign req_ready = gnt_oh;
  assign xfer      = |gnt_oh;
  assign nxt_ptr   = (gnt_idx == LAST) ? '0 : gnt_idx + PTR_W'(1);

  always_comb begin
    sel_idx = '0;
    sel_val = '0;
    sel_bm  = 1'b0;
    sel_ex  = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (gnt_oh[u]) begin
        sel_idx = req_entry_index[u*IDX_W +: IDX_W];
        sel_val = req_ex_val[u*DATA_W +: DATA_W];
        sel_bm  = req_br_mispred[u];
        sel_ex  = req_exception[u];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      entry_index <= '0;
      ex_val      <= '0;
      br_mispred  <= 1'b0;
      exception   <= 1'b0;
      completions <= '0;
      rr_ptr      <= '0;
    end else begin
      ex_valid <= xfer;
      if (xfer) begin
        entry_index <= sel_idx;
        ex_val      <= sel_val;
        br_mispred  <= sel_bm;
        exception   <= sel_ex;
        rr_ptr      <= nxt_ptr;
        completions <= completions + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// tb_rob_complete_arbiter: directed + random checks against a queue-free
// behavioural model of the round-robin completion arbiter.
module tb_rob_complete_arbiter;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int DW = 32;
  localparam int CW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*IW-1:0] req_entry_index;
  logic [N*DW-1:0] req_ex_val;
  logic [N-1:0]    req_br_mispred;
  logic [N-1:0]    req_exception;
  logic            ex_valid;
  logic [IW-1:0]   entry_index;
  logic [DW-1:0]   ex_val;
  logic            br_mispred;
  logic            exception;
  logic [CW-1:0]   completions;

  rob_complete_arbiter #(
    .NUM_UNITS(N), .RS_ENTRIES(16), .DATA_W(DW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_entry_index(req_entry_index), .req_ex_val(req_ex_val),
    .req_br_mispred(req_br_mispred), .req_exception(req_exception),
    .ex_valid(ex_valid), .entry_index(entry_index), .ex_val(ex_val),
    .br_mispred(br_mispred), .exception(exception),
    .completions(completions)
  );

  always #5 clk = ~clk;

  // per-unit pending completion
  bit          pv  [N];
  int unsigned pidx[N];
  int unsigned pval[N];
  bit          pbm [N];
  bit          pex [N];

  // model state
  int          m_ptr;
  longint      m_cnt;
  bit          m_vld;
  int unsigned m_idx;
  int unsigned m_val;
  bit          m_bm;
  bit          m_ex;
  int          last_g;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int u;
      u = (m_ptr + i) % N;
      if (pv[u]) return u;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int u = 0; u < N; u++) begin
      req_valid[u]              = pv[u];
      req_entry_index[u*IW+:IW] = pidx[u][IW-1:0];
      req_ex_val[u*DW+:DW]      = pval[u];
      req_br_mispred[u]         = pbm[u];
      req_exception[u]          = pex[u];
    end
  endtask

  task automatic set_unit(input int u, input int unsigned idx,
                          input int unsigned val, input bit bm,
                          input bit ex);
    pv[u] = 1; pidx[u] = idx; pval[u] = val; pbm[u] = bm; pex[u] = ex;
  endtask

  // One clock: inputs set after negedge, ready checked, outputs after posedge.
  task automatic step(input bit f, input bit r);
    int g;
    logic [N-1:0] exp_rdy;
    flush = f;
    rst   = r;
    drive();
    #1;
    g = (f || r) ? -1 : pick();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    last_g = g;
    @(posedge clk);
    if (r) begin
      m_ptr = 0; m_cnt = 0; m_vld = 0;
      m_idx = 0; m_val = 0; m_bm = 0; m_ex = 0;
    end else if (g >= 0) begin
      m_vld = 1; m_idx = pidx[g] % 16; m_val = pval[g];
      m_bm = pbm[g]; m_ex = pex[g];
      m_ptr = (g + 1) % N;
      m_cnt = (m_cnt + 1) % (64'd1 << CW);
      pv[g] = 0;
    end else begin
      m_vld = 0;
    end
    #1;
    check("ex_valid",    ex_valid,    m_vld);
    check("entry_index", entry_index, m_idx[IW-1:0]);
    check("ex_val",      ex_val,      m_val);
    check("br_mispred",  br_mispred,  m_bm);
    check("exception",   exception,   m_ex);
    check("completions", completions, m_cnt[CW-1:0]);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; flush = 0;
    req_valid = '0; req_entry_index = '0; req_ex_val = '0;
    req_br_mispred = '0; req_exception = '0;
    for (int u = 0; u < N; u++) begin
      pv[u] = 0; pidx[u] = 0; pval[u] = 0; pbm[u] = 0; pex[u] = 0;
    end
    m_ptr = 0; m_cnt = 0; m_vld = 0;
    m_idx = 0; m_val = 0; m_bm = 0; m_ex = 0;
    @(negedge clk);

    // reset then idle
    step(0, 1); step(0, 1);
    repeat (5) step(0, 0);

    // single request from unit 2
    set_unit(2, 5, 32'hDEADBEEF, 0, 0);
    step(0, 0);
    check("single_grant", last_g, 2);
    check("single_val", ex_val, 32'hDEADBEEF);
    step(0, 1);

    // all units continuously valid from rr_ptr=0
    for (int k = 0; k < 8; k++) begin
      for (int u = 0; u < N; u++)
        if (!pv[u]) set_unit(u, (k * 4 + u) % 16, 32'h1000 + k * 4 + u, 0, 0);
      step(0, 0);
      check("rr_order", last_g, k % N);
    end
    check("cnt8", completions, 8);
    for (int u = 0; u < N; u++) pv[u] = 0;

    // flagged completions
    set_unit(1, 9, 32'h11, 1, 0);
    step(0, 0);
    check("bm_flag", {br_mispred, exception, entry_index}, {2'b10, 4'd9});
    set_unit(3, 15, 32'h33, 0, 1);
    step(0, 0);
    check("ex_flag", {br_mispred, exception, entry_index}, {2'b01, 4'd15});

    // flush with units 0 and 1 pending (rr_ptr=0 now)
    set_unit(0, 1, 32'hA0, 0, 0);
    set_unit(1, 2, 32'hA1, 0, 0);
    step(1, 0);
    step(0, 0);
    check("post_flush", last_g, 0);
    step(0, 0);

    // reset mid-stream after three grants
    step(0, 1);
    for (int k = 0; k < 3; k++) begin
      for (int u = 0; u < N; u++)
        if (!pv[u]) set_unit(u, u + 4, 32'hB0 + u, 0, 0);
      step(0, 0);
    end
    for (int u = 0; u < N; u++)
      if (!pv[u]) set_unit(u, u + 8, 32'hC0 + u, 0, 0);
    step(0, 1);
    step(0, 0);
    check("post_rst", last_g, 0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < N; u++)
        if (!pv[u] && ($urandom % 2 == 0))
          set_unit(u, $urandom % 16, $urandom,
                   bit'($urandom % 2), bit'($urandom % 2));
      step(bit'($urandom % 10 == 0), bit'($urandom % 50 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_complete_arbiter.md
Name: rob_complete_arbiter

Overview:
- Merges completion results from NUM_UNITS execution units onto the single Execute→ROB completion port: ex_valid, entry_index, ex_val, br_mispred, exception.
- Grants at most one unit per cycle using round-robin and registers the winner's payload toward the ROB.
- Sits between the functional units' writeback outputs and the ROB.
- The ROB port has no backpressure, so the arbiter owns all flow control through per-unit ready signals.

Parameters:
- NUM_UNITS, 4, number of completing execution units (≥2).
- RS_ENTRIES, 16, entry count; IDX_W = $clog2(RS_ENTRIES).
- DATA_W, 32, width of the result value.
- CNT_W, 32, width of the completion statistics counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush (mispredict or exception recovery).
- req_valid  in  NUM_UNITS  unit u has a completion pending.
- req_ready  out  NUM_UNITS  unit u's completion is accepted this cycle.
- req_entry_index  in  NUM_UNITS*IDX_W  packed per-unit entry index; unit u occupies [u*IDX_W +: IDX_W].
- req_ex_val  in  NUM_UNITS*DATA_W  packed per-unit result value.
- req_br_mispred  in  NUM_UNITS  per-unit branch-mispredict flag.
- req_exception  in  NUM_UNITS  per-unit exception flag.
- ex_valid  out  1  registered completion valid to ROB.
- entry_index  out  IDX_W  registered entry index.
- ex_val  out  DATA_W  registered result value.
- br_mispred  out  1  registered mispredict flag.
- exception  out  1  registered exception flag.
- completions  out  CNT_W  count of completions issued since reset.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - All state updates on posedge clk.
  - When rst=1 at an edge, the following are cleared: ex_valid, entry_index, ex_val, br_mispred, exception, completions, rr_ptr.
  - rst has priority over flush and over any request.
- Round-robin pointer:
  - rr_ptr is a $clog2(NUM_UNITS)-bit register.
  - Search order is rr_ptr, rr_ptr+1, …, NUM_UNITS-1, 0, …, rr_ptr-1.
  - The first unit in that order with req_valid=1 is the winner g.
- Grant:
  - req_ready is combinational: req_ready[g]=1 only when flush=0 and rst=0; all other bits are 0.
  - A unit whose req_valid=0 is never granted.
  - Units must not derive req_valid from req_ready; the arbiter has no combinational path from req_ready back into the grant.
  - A transfer occurs for unit u when req_valid[u] & req_ready[u].
  - A unit holds its valid and payload stable until it is accepted.
- Output register (latency 1):
  - On a transfer at edge N, ex_valid=1 after edge N and the output carries unit g's entry_index, ex_val, br_mispred and exception.
  - If no transfer occurs, ex_valid=0 and the payload outputs hold their previous values.
  - ex_valid stays high for exactly one cycle per transfer.
  - Back-to-back transfers produce ex_valid=1 on consecutive cycles (full throughput, 1 completion/cycle).
- Pointer update:
  - After a transfer, rr_ptr <= (g+1) mod NUM_UNITS; the wrap from NUM_UNITS-1 goes to 0.
  - With no transfer, rr_ptr holds.
  - Fairness bound: a continuously valid unit is granted within NUM_UNITS cycles.
- Flush:
  - While flush=1, no grant is made (req_ready=0).
  - After the edge, ex_valid=0.
  - Flush overrides a same-cycle request: that request is not accepted and the unit must drop or re-present it per its own flush handling.
  - rr_ptr and completions hold across flush.
  - A completion already registered before the flush edge is presented during the flush cycle. The ROB discards it as part of its own flush.
- Counter:
  - completions increments by 1 on every transfer.
  - It wraps modulo 2^CNT_W.
  - It is not cleared by flush.
- Flag pass-through: br_mispred and exception are passed through unchanged. The arbiter gives no priority to flagged completions; age ordering is the ROB's job.
- Reset mid-operation: pending requests are not accepted in the reset cycle, and rr_ptr restarts at 0.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then all req_valid=0 for 5 cycles.
  - Required: ex_valid=0, completions=0, req_ready=0 throughout.
- Single request:
  - Stimulus: unit 2 valid with entry_index=5, ex_val=32'hDEADBEEF, other flags 0.
  - Required: req_ready=4'b0100 in the same cycle; next cycle ex_valid=1, entry_index=5, ex_val=DEADBEEF; rr_ptr=3; completions=1.
- All units valid continuously for 8 cycles, starting at rr_ptr=0:
  - Required: grants go 0,1,2,3,0,1,2,3 (wrap from 3 to 0); ex_valid=1 on 8 consecutive cycles starting one cycle after the first grant; completions=8.
- Flags:
  - Stimulus: unit 1 alone with br_mispred=1, entry_index=9; then unit 3 alone with exception=1, entry_index=15.
  - Required: each flag appears on the output one cycle after its grant, with the matching index and the other flag 0.
- Flush:
  - Stimulus: units 0 and 1 valid; flush=1 for one cycle.
  - Required: req_ready=0 during flush; ex_valid=0 after the edge; rr_ptr and completions unchanged; the cycle after flush deasserts, unit at rr_ptr is granted.
- Reset mid-stream:
  - Stimulus: after 3 grants (rr_ptr=3), assert rst with all units valid.
  - Required: no grant that cycle; outputs and completions cleared; first grant after reset goes to unit 0.
